// File: rtl/tcm_ram_arb.sv
// ----------------------------------------------------------------------------
// tcm_ram_arb
// Two-port round-robin arbiter in front of a single pipelined TCM RAM port.
// Port 0 is the CPU data side and port 1 is the AXI pmem bridge. Each
// request that the RAM takes is tagged with its port index in a small FIFO.
// RAM responses come back in request order, so the FIFO head steers each
// ack to the right requester with zero latency.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   pN_rd_i / pN_wr_i         port N read request / byte write strobes
//   pN_addr_i, pN_write_data_i
//   pN_accept_o               port N request taken this cycle
//   pN_ack_o, pN_error_o      port N response valid / error
//   pN_read_data_o            response data (shared by both ports)
//   ram_rd_o, ram_wr_o, ram_addr_o, ram_write_data_o   RAM request
//   ram_accept_i              RAM took the request
//   ram_ack_i, ram_error_i, ram_read_data_i            RAM response
// ----------------------------------------------------------------------------
module tcm_ram_arb #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        p0_rd_i,
    input  logic [3:0]  p0_wr_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_write_data_i,
    output logic        p0_accept_o,
    output logic        p0_ack_o,
    output logic        p0_error_o,
    output logic [31:0] p0_read_data_o,

    input  logic        p1_rd_i,
    input  logic [3:0]  p1_wr_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_write_data_i,
    output logic        p1_accept_o,
    output logic        p1_ack_o,
    output logic        p1_error_o,
    output logic [31:0] p1_read_data_o,

    output logic        ram_rd_o,
    output logic [3:0]  ram_wr_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_write_data_o,
    input  logic        ram_accept_i,
    input  logic        ram_ack_i,
    input  logic        ram_error_i,
    input  logic [31:0] ram_read_data_i
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    logic             prio_q, prio_d;
    logic             hold_vld_q, hold_vld_d;
    logic             hold_port_q, hold_port_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_q [OUTSTANDING];

    logic req0, req1;
    logic gnt_port;
    logic gnt_vld;
    logic gnt_rd;
    logic [3:0] gnt_wr;
    logic full;
    logic not_empty;
    logic push;
    logic pop;
    logic head;

    assign req0 = p0_rd_i | (|p0_wr_i);
    assign req1 = p1_rd_i | (|p1_wr_i);

    // A held grant overrides round-robin. If the held port has withdrawn,
    // nothing is presented this cycle and the hold clears on the next edge.
    always_comb begin
        gnt_port = 1'b0;
        if (hold_vld_q) begin
            gnt_port = hold_port_q;
        end else if (req0 && req1) begin
            gnt_port = prio_q;
        end else if (req1) begin
            gnt_port = 1'b1;
        end
    end

    assign gnt_vld = gnt_port ? req1 : req0;
    assign gnt_rd  = gnt_port ? p1_rd_i : p0_rd_i;
    assign gnt_wr  = gnt_port ? p1_wr_i : p0_wr_i;

    assign full      = (count_q == CNT_FULL);
    assign not_empty = (count_q != '0);

    // A full tracking FIFO blocks the request even if a pop lands this cycle.
    assign ram_rd_o         = gnt_vld & gnt_rd & ~full;
    assign ram_wr_o         = (gnt_vld & ~full) ? gnt_wr : 4'b0000;
    assign ram_addr_o       = gnt_port ? p1_addr_i : p0_addr_i;
    assign ram_write_data_o = gnt_port ? p1_write_data_i : p0_write_data_i;

    assign push = gnt_vld & ram_accept_i & ~full;
    assign pop  = ram_ack_i & not_empty;
    assign head = fifo_q[rd_ptr_q];

    assign p0_accept_o = push & ~gnt_port;
    assign p1_accept_o = push &  gnt_port;

    assign p0_ack_o   = pop & ~head;
    assign p1_ack_o   = pop &  head;
    assign p0_error_o = p0_ack_o & ram_error_i;
    assign p1_error_o = p1_ack_o & ram_error_i;

    assign p0_read_data_o = ram_read_data_i;
    assign p1_read_data_o = ram_read_data_i;

    always_comb begin
        prio_d      = prio_q;
        hold_vld_d  = 1'b0;
        hold_port_d = hold_port_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            prio_d   = ~gnt_port;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (gnt_vld && !ram_accept_i) begin
            hold_vld_d  = 1'b1;
            hold_port_d = gnt_port;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_port_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            prio_q      <= prio_d;
            hold_vld_q  <= hold_vld_d;
            hold_port_q <= hold_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= gnt_port;
        end
    end

endmodule

// File: tb/tb_tcm_ram_arb.sv
module tb_tcm_ram_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        p0_rd_i, p1_rd_i;
    logic [3:0]  p0_wr_i, p1_wr_i;
    logic [31:0] p0_addr_i, p1_addr_i, p0_write_data_i, p1_write_data_i;
    logic        p0_accept_o, p0_ack_o, p0_error_o;
    logic        p1_accept_o, p1_ack_o, p1_error_o;
    logic [31:0] p0_read_data_o, p1_read_data_o;
    logic        ram_rd_o;
    logic [3:0]  ram_wr_o;
    logic [31:0] ram_addr_o, ram_write_data_o;
    logic        ram_accept_i, ram_ack_i, ram_error_i;
    logic [31:0] ram_read_data_i;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    tcm_ram_arb #(.OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_rd_i(p0_rd_i), .p0_wr_i(p0_wr_i), .p0_addr_i(p0_addr_i),
        .p0_write_data_i(p0_write_data_i), .p0_accept_o(p0_accept_o),
        .p0_ack_o(p0_ack_o), .p0_error_o(p0_error_o), .p0_read_data_o(p0_read_data_o),
        .p1_rd_i(p1_rd_i), .p1_wr_i(p1_wr_i), .p1_addr_i(p1_addr_i),
        .p1_write_data_i(p1_write_data_i), .p1_accept_o(p1_accept_o),
        .p1_ack_o(p1_ack_o), .p1_error_o(p1_error_o), .p1_read_data_o(p1_read_data_o),
        .ram_rd_o(ram_rd_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
        .ram_write_data_o(ram_write_data_o), .ram_accept_i(ram_accept_i),
        .ram_ack_i(ram_ack_i), .ram_error_i(ram_error_i), .ram_read_data_i(ram_read_data_i)
    );

    typedef struct {
        logic       p0_rd;
        logic [3:0] p0_wr;
        logic       p1_rd;
        logic [3:0] p1_wr;
        logic       acc, ack, err;
        logic       e_rd;
        logic [3:0] e_wr;
        logic       e_gnt;
        logic       e_a0, e_a1, e_k0, e_k1, e_e0, e_e1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic p0r, logic [3:0] p0w, logic p1r, logic [3:0] p1w,
                               logic acc, logic ack, logic err,
                               logic erd, logic [3:0] ewr, logic egnt,
                               logic ea0, logic ea1, logic ek0, logic ek1,
                               logic ee0, logic ee1);
        vec_t r;
        r.p0_rd = p0r; r.p0_wr = p0w; r.p1_rd = p1r; r.p1_wr = p1w;
        r.acc = acc; r.ack = ack; r.err = err;
        r.e_rd = erd; r.e_wr = ewr; r.e_gnt = egnt;
        r.e_a0 = ea0; r.e_a1 = ea1; r.e_k0 = ek0; r.e_k1 = ek1;
        r.e_e0 = ee0; r.e_e1 = ee1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p0r, input logic [3:0] p0w, input logic p1r,
                         input logic [3:0] p1w, input logic acc, input logic ack,
                         input logic err);
        p0_rd_i = p0r; p0_wr_i = p0w; p1_rd_i = p1r; p1_wr_i = p1w;
        ram_accept_i = acc; ram_ack_i = ack; ram_error_i = err;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(0, 4'h0, 0, 4'h0, 0, 0, 0);
        p0_addr_i = 32'h0000_0100; p0_write_data_i = 32'h1111_1111;
        p1_addr_i = 32'h0000_0200; p1_write_data_i = 32'h2222_2222;
        ram_read_data_i = 32'hDEAD_BEEF;

        // idle + alternation from reset, acks in order, error routing, spurious ack
        vecs.push_back(v(0,4'h0,0,4'h0, 0,0,0, 0,4'h0,0, 0,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,1,4'h0, 1,0,0, 1,4'h0,0, 1,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,1,4'h0, 1,1,0, 1,4'h0,1, 0,1,1,0,0,0));
        vecs.push_back(v(1,4'h0,1,4'h0, 1,1,0, 1,4'h0,0, 1,0,0,1,0,0));
        vecs.push_back(v(1,4'h0,1,4'h0, 1,1,1, 1,4'h0,1, 0,1,1,0,1,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,1, 0,4'h0,0, 0,0,0,1,0,1));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,1, 0,4'h0,0, 0,0,0,0,0,0));
        // single p0 read, then its response
        vecs.push_back(v(1,4'h0,0,4'h0, 1,0,0, 1,4'h0,0, 1,0,0,0,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,1,0,0,0));
        // p1 alone moves priority to port 0
        vecs.push_back(v(0,4'h0,1,4'h0, 1,0,0, 1,4'h0,1, 0,1,0,0,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,0,1,0,0));
        // hold: p1 write stalled 3 cycles, p0 joins (priority favours p0)
        vecs.push_back(v(0,4'h0,0,4'hF, 0,0,0, 0,4'hF,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'hF, 0,0,0, 0,4'hF,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'hF, 0,0,0, 0,4'hF,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'hF, 1,0,0, 0,4'hF,1, 0,1,0,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'hF, 1,0,0, 1,4'h0,0, 1,0,0,0,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,0,1,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,1,0,0,0));
        // fill to OUTSTANDING, blocked, blocked even with a pop, then accepted
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1,4'h0,0,4'h0, 1,0,0, 1,4'h0,0, 1,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'h0, 1,0,0, 0,4'h0,0, 0,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'h0, 1,1,0, 0,4'h0,0, 0,0,1,0,0,0));
        vecs.push_back(v(1,4'h0,0,4'h0, 1,0,0, 1,4'h0,0, 1,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,1,0,0,0));
        // hold on p0 then withdraw; hold must not stick (priority is port 1)
        vecs.push_back(v(1,4'h0,0,4'h0, 0,0,0, 1,4'h0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,0,0, 0,4'h0,0, 0,0,0,0,0,0));
        vecs.push_back(v(1,4'h0,1,4'h0, 1,0,0, 1,4'h0,1, 0,1,0,0,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,0,1,0,0));
        // read and write strobes together pass through unchanged
        vecs.push_back(v(1,4'h3,0,4'h0, 1,0,0, 1,4'h3,0, 1,0,0,0,0,0));
        vecs.push_back(v(0,4'h0,0,4'h0, 0,1,0, 0,4'h0,0, 0,0,1,0,0,0));

        // reset state, checked while still in reset
        #2;
        chk("rst_ram_rd", ram_rd_o, 0);
        chk("rst_ram_wr", ram_wr_o, 0);
        chk("rst_p0_ack", p0_ack_o, 0);
        chk("rst_p1_ack", p1_ack_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk_i); #1;
            drive(vecs[i].p0_rd, vecs[i].p0_wr, vecs[i].p1_rd, vecs[i].p1_wr,
                  vecs[i].acc, vecs[i].ack, vecs[i].err);
            ram_read_data_i = 32'hDEAD_BEEF ^ 32'(i);
            @(negedge clk_i);
            chk($sformatf("v%0d ram_rd", i), ram_rd_o, vecs[i].e_rd);
            chk($sformatf("v%0d ram_wr", i), ram_wr_o, vecs[i].e_wr);
            if (vecs[i].e_rd || vecs[i].e_wr != 4'h0) begin
                chk($sformatf("v%0d ram_addr", i), ram_addr_o,
                    vecs[i].e_gnt ? 32'h0000_0200 : 32'h0000_0100);
                chk($sformatf("v%0d ram_wdata", i), ram_write_data_o,
                    vecs[i].e_gnt ? 32'h2222_2222 : 32'h1111_1111);
            end
            chk($sformatf("v%0d p0_accept", i), p0_accept_o, vecs[i].e_a0);
            chk($sformatf("v%0d p1_accept", i), p1_accept_o, vecs[i].e_a1);
            chk($sformatf("v%0d p0_ack", i), p0_ack_o, vecs[i].e_k0);
            chk($sformatf("v%0d p1_ack", i), p1_ack_o, vecs[i].e_k1);
            chk($sformatf("v%0d p0_error", i), p0_error_o, vecs[i].e_e0);
            chk($sformatf("v%0d p1_error", i), p1_error_o, vecs[i].e_e1);
            chk($sformatf("v%0d p0_rdata", i), p0_read_data_o, 32'hDEAD_BEEF ^ 32'(i));
            chk($sformatf("v%0d p1_rdata", i), p1_read_data_o, 32'hDEAD_BEEF ^ 32'(i));
        end

        // reset mid-transaction: two outstanding (p1 then p0, prio ends at 1)
        @(posedge clk_i); #1;
        drive(0, 4'h0, 1, 4'h0, 1, 0, 0);
        @(negedge clk_i);
        chk("rs p1_accept", p1_accept_o, 1);
        @(posedge clk_i); #1;
        drive(1, 4'h0, 0, 4'h0, 1, 0, 0);
        @(negedge clk_i);
        chk("rs p0_accept", p0_accept_o, 1);
        @(posedge clk_i); #1;
        drive(0, 4'h0, 0, 4'h0, 0, 1, 0);
        rst_ni = 1'b0;
        #1;
        chk("rs in-reset p0_ack", p0_ack_o, 0);
        chk("rs in-reset p1_ack", p1_ack_o, 0);
        chk("rs count", 32'(dut.count_q), 0);
        chk("rs prio", 32'(dut.prio_q), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rs post p0_ack", p0_ack_o, 0);
        chk("rs post p1_ack", p1_ack_o, 0);
        @(posedge clk_i); #1;
        chk("rs post count", 32'(dut.count_q), 0);
        drive(1, 4'h0, 1, 4'h0, 1, 0, 0);
        @(negedge clk_i);
        chk("rs post p0 wins", p0_accept_o, 1);
        chk("rs post p1 loses", p1_accept_o, 0);
        @(posedge clk_i); #1;
        drive(0, 4'h0, 0, 4'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
